// File: rtl/unpack_signed.sv
// Signed LEB128 decoder: up to MAXB bytes in, one registered N-bit value and byte count out per cycle.
// Optional macro UNPACK_SIGNED_ERR_EN adds a registered err output (missing terminator or overflow).
module unpack_signed #(
   parameter int N = 64,
   localparam int MAXB = (N + 6) / 7,
   localparam int LW = $clog2(MAXB + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [8*MAXB-1:0] in,
   output logic [N-1:0]      out,
   output logic [LW-1:0]     len
`ifdef UNPACK_SIGNED_ERR_EN
   ,
   output logic              err
`endif
);

   logic [N-1:0]  out_d, out_q;
   logic [LW-1:0] len_d, len_q;
   logic          err_d;
   logic          found;
   logic          sext;
   logic          mis;
   logic          ovf;
   int            stop;

   // Bytes after the terminator are never read once found is set, so they cannot disturb the result.
   always_comb begin
      out_d = '0;
      len_d = '0;
      found = 1'b0;
      sext  = 1'b0;
      mis   = 1'b0;
      ovf   = 1'b0;
      stop  = N;
      for (int k = 0; k < MAXB; k++) begin
         if (!found) begin
            mis = 1'b0;
            for (int j = 0; j < 7; j++) begin
               if (7*k + j < N)
                  out_d[7*k + j] = in[8*(MAXB-1-k) + j];
               else
                  mis = mis | (in[8*(MAXB-1-k) + j] != out_d[N-1]);
            end
            if (!in[8*(MAXB-1-k) + 7]) begin
               found = 1'b1;
               len_d = LW'(k + 1);
               sext  = in[8*(MAXB-1-k) + 6];
               stop  = 7*(k + 1);
               ovf   = (k == MAXB-1) && mis;
            end
         end
      end
      if (found && sext) begin
         for (int i = 0; i < N; i++) begin
            if (i >= stop)
               out_d[i] = 1'b1;
         end
      end
      err_d = !found || ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         len_q <= '0;
      end else begin
         out_q <= out_d;
         len_q <= len_d;
      end
   end

   assign out = out_q;
   assign len = len_q;

`ifdef UNPACK_SIGNED_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign err = err_q;
`else
   logic unused_err;
   assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_unpack_signed.sv
// Scoreboard bench for unpack_signed (N=64): expected results queued at drive time, checked one edge later.
module tb_unpack_signed;

   localparam int N    = 64;
   localparam int MAXB = 10;
   localparam int LW   = 4;

   typedef struct {
      logic [N-1:0]  o;
      logic [LW-1:0] l;
      logic          e;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [8*MAXB-1:0] din;
   logic [N-1:0]      dout;
   logic [LW-1:0]     dlen;
`ifdef UNPACK_SIGNED_ERR_EN
   logic              derr;
`endif

   exp_t q[$];
   int   n_cmp;
   int   n_err;

   unpack_signed #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .in  (din),
      .out (dout),
      .len (dlen)
`ifdef UNPACK_SIGNED_ERR_EN
      ,
      .err (derr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference decode: shift payloads in from the terminator backwards, then sign-extend arithmetically.
   function automatic exp_t model(input logic [8*MAXB-1:0] v);
      exp_t        r;
      int          t;
      int          last;
      logic [69:0] acc;
      t = -1;
      for (int k = 0; k < MAXB; k++)
         if (t < 0 && !v[79 - 8*k]) t = k;
      last = (t < 0) ? MAXB - 1 : t;
      acc = '0;
      for (int k = last; k >= 0; k--)
         acc = (acc << 7) | 70'(v[78 - 8*k -: 7]);
      if (t >= 0 && v[78 - 8*t] && 7*(t + 1) < N)
         acc = acc | ~((70'd1 << (7*(t + 1))) - 70'd1);
      r.o = acc[N-1:0];
      r.l = (t < 0) ? 4'd0 : 4'(t + 1);
      r.e = (t < 0) || (t == MAXB - 1 && acc[69:64] != {6{acc[63]}});
      return r;
   endfunction

   task automatic drive_exp(input logic r, input logic [8*MAXB-1:0] v,
                            input logic [N-1:0] eo, input logic [LW-1:0] el, input logic ee);
      exp_t x;
      @(negedge clk);
      rst = r;
      din = v;
      x.o = eo;
      x.l = el;
      x.e = ee;
      q.push_back(x);
   endtask

   task automatic drive(input logic r, input logic [8*MAXB-1:0] v);
      exp_t x;
      x = r ? exp_t'{o: '0, l: '0, e: 1'b0} : model(v);
      drive_exp(r, v, x.o, x.l, x.e);
   endtask

   function automatic logic [8*MAXB-1:0] rand_stream(input int t);
      logic [8*MAXB-1:0] v;
      for (int k = 0; k < MAXB; k++) begin
         v[79 - 8*k -: 8] = 8'($urandom);
         if (k < t) v[79 - 8*k] = 1'b1;
         if (k == t) v[79 - 8*k] = 1'b0;
      end
      return v;
   endfunction

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("out", 128'(dout), 128'(x.o));
         chk("len", 128'(dlen), 128'(x.l));
`ifdef UNPACK_SIGNED_ERR_EN
         chk("err", 128'(derr), 128'(x.e));
`endif
      end
   end

   initial begin
      logic [8*MAXB-1:0] v;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      din = '0;

      drive_exp(1'b1, 80'h7fffffffffffffffffff, 64'd0, 4'd0, 1'b0);
      drive_exp(1'b1, 80'h7f000000000000000000, 64'd0, 4'd0, 1'b0);
      drive_exp(1'b0, 80'h7f000000000000000000, 64'hffffffffffffffff, 4'd1, 1'b0);

      v = {8'h01, 72'(({$urandom, $urandom, $urandom}))};
      drive_exp(1'b0, v, 64'd1, 4'd1, 1'b0);
      drive_exp(1'b0, 80'hffffffffffffffffff01, 64'hffffffffffffffff, 4'd10, 1'b1);
      drive_exp(1'b0, 80'h808080800cbc0b000000, 64'h00000000c0000000, 4'd5, 1'b0);
      drive_exp(1'b0, 80'h7f000000000000000000, 64'hffffffffffffffff, 4'd1, 1'b0);
      drive_exp(1'b0, 80'hffffffffffffffffffff, 64'hffffffffffffffff, 4'd0, 1'b1);
      drive_exp(1'b0, 80'h3f000000000000000000, 64'h000000000000003f, 4'd1, 1'b0);
      drive_exp(1'b0, 80'hffffffffffffffffff7f, 64'hffffffffffffffff, 4'd10, 1'b0);
      drive_exp(1'b0, 80'h80808080808080808000, 64'd0, 4'd10, 1'b0);

      for (int i = 0; i < 200; i++)
         drive(1'b0, rand_stream($urandom_range(0, MAXB)));

      drive(1'b1, rand_stream(2));
      drive(1'b0, rand_stream(9));
      for (int t = 0; t <= MAXB; t++)
         drive(1'b0, rand_stream(t));

      @(negedge clk);
      @(negedge clk);
      chk("drain", 128'(q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
